lsu_mem_ctrl: RTL and testbench

- Load/store initiator that drives the word-wide data-memory port (16-bit word address, 32-bit async-read data, single write enable) on behalf of the RV32 MEM stage.
- Supports LB/LH/LW/LBU/LHU/SB/SH/SW; byte/halfword stores use read-modify-write because the memory has no byte strobes.
- Sits between the pipeline MEM stage and the data memory; the pipeline stalls while req_ready=0.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_load_align.sv | 26 ++
 rtl/lsu_mem_ctrl.sv | 175 +++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and lane helpers for the load/store unit.
// Word-lane masks are used by the read-modify-write merge for byte/halfword stores.
package lsu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RMW_RD,
      ST_RMW_WR,
      ST_RESP
   } lsu_state_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Bits of the word owned by a byte (half=0) or halfword (half=1) at the given lane.
   function automatic logic [31:0] lane_mask(input logic [1:0] lane, input logic half);
      logic [31:0] m;
      if (half) begin
         m = 32'h0000_FFFF << {lane[1], 4'b0000};
      end else begin
         m = 32'h0000_00FF << {lane, 3'b000};
      end
      return m;
   endfunction

   function automatic logic [31:0] lane_replicate(input logic [15:0] d, input logic half);
      return half ? {2{d}} : {4{d[7:0]}};
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword of a memory word and extends it per funct3.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [31:0] shifted;

   always_comb begin
      shifted = word >> {lane, 3'b000};
      data    = '0;
      case (funct3)
         F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
         F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
         F3_LW:   data = word;
         F3_LBU:  data = {24'h00_0000, shifted[7:0]};
         F3_LHU:  data = {16'h0000, shifted[15:0]};
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// RV32 load/store controller for a word-wide memory without byte strobes.
// Define LSU_ADDR_CHECK_EN to fault on byte addresses beyond the 256 KiB window.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_LSB = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [15:0] mem_a,
   output logic        mem_we,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_spo
);

`ifdef LSU_ADDR_CHECK_EN
   localparam bit ADDR_CHECK = 1'b1;
`else
   localparam bit ADDR_CHECK = 1'b0;
`endif

   lsu_state_e  state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  lane_q, lane_d;
   logic [15:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic [15:0] mem_a_q, mem_a_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_din_q, mem_din_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;

   logic        accept;
   logic        f3_bad;
   logic        misalign;
   logic        addr_fault;
   logic        req_err;
   logic        req_rmw;
   logic [15:0] req_idx;
   logic [31:0] addr_hi;
   logic [31:0] load_data;
   logic [31:0] merge_mask;

   assign accept     = req_valid && req_ready;
   assign req_idx    = req_addr[ADDR_LSB+15:ADDR_LSB];
   assign addr_hi    = req_addr >> (ADDR_LSB + 16);
   assign addr_fault = ADDR_CHECK && (addr_hi != 32'd0);
   assign merge_mask = lane_mask(lane_q, funct3_q[0]);

   always_comb begin
      if (req_we) begin
         f3_bad = (req_funct3 > 3'd2);
      end else begin
         f3_bad = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
      end
      misalign = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
      req_err  = f3_bad || misalign || addr_fault;
      req_rmw  = req_we && !req_err && (req_funct3[1:0] != 2'd2);
   end

   lsu_load_align u_load_align (
      .word   (mem_spo),
      .lane   (lane_q),
      .funct3 (funct3_q),
      .data   (load_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         we_q         <= 1'b0;
         funct3_q     <= '0;
         lane_q       <= '0;
         wdata_q      <= '0;
         err_q        <= 1'b0;
         mem_a_q      <= '0;
         mem_we_q     <= 1'b0;
         mem_din_q    <= '0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         funct3_q     <= funct3_d;
         lane_q       <= lane_d;
         wdata_q      <= wdata_d;
         err_q        <= err_d;
         mem_a_q      <= mem_a_d;
         mem_we_q     <= mem_we_d;
         mem_din_q    <= mem_din_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Errors still pass through ACCESS (with memory idle) so they complete in two cycles.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (accept) state_d = req_rmw ? ST_RMW_RD : ST_ACCESS;
         ST_ACCESS: state_d = ST_RESP;
         ST_RMW_RD: state_d = ST_RMW_WR;
         ST_RMW_WR: state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      we_d         = we_q;
      funct3_d     = funct3_q;
      lane_d       = lane_q;
      wdata_d      = wdata_q;
      err_d        = err_q;
      mem_a_d      = '0;
      mem_we_d     = 1'b0;
      mem_din_d    = '0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               lane_d   = req_addr[1:0];
               wdata_d  = req_wdata[15:0];
               err_d    = req_err;
               if (!req_err) begin
                  mem_a_d = req_idx;
                  if (req_we && !req_rmw) begin
                     mem_we_d  = 1'b1;
                     mem_din_d = req_wdata;
                  end
               end
            end
         end
         ST_ACCESS: begin
            resp_err_d   = err_q;
            resp_rdata_d = (err_q || we_q) ? 32'd0 : load_data;
         end
         ST_RMW_RD: begin
            mem_a_d   = mem_a_q;
            mem_we_d  = 1'b1;
            mem_din_d = (mem_spo & ~merge_mask) |
                        (lane_replicate(wdata_q, funct3_q[0]) & merge_mask);
         end
         ST_RMW_WR: begin
            resp_err_d   = 1'b0;
            resp_rdata_d = 32'd0;
         end
         default: ;
      endcase
   end

   // Reset suppresses the write strobe and response in the very cycle it is asserted.
   assign req_ready  = (state_q == ST_IDLE) && !rst;
   assign resp_valid = (state_q == ST_RESP) && !rst;
   assign mem_we     = mem_we_q && !rst;
   assign mem_a      = mem_a_q;
   assign mem_din    = mem_din_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed test-plan cases plus a randomized
// request stream checked against a byte-level reference model of the memory.
module tb_lsu_mem_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [15:0] mem_a;
   logic        mem_we;
   logic [31:0] mem_din;
   logic [31:0] mem_spo;

   logic [31:0] tb_mem  [0:65535];
   logic [31:0] ref_mem [0:65535];
   logic        pre_we;
   logic [15:0] pre_a;
   logic [31:0] pre_d;

   int n_cmp;
   int n_fail;

   int          obs_lat;
   int          obs_we_cnt;
   int          obs_we_k;
   logic [15:0] obs_we_a;
   logic [31:0] obs_we_din;
   logic [15:0] obs_a1;
   logic        obs_we1;
   logic [31:0] obs_rdata;
   logic        obs_err;
   logic        obs_ready_issue;
   logic        obs_ready_resp;

   logic        exp_err;
   logic [31:0] exp_rdata;
   int          exp_lat;
   logic [15:0] exp_word;
   logic [31:0] exp_new;
   logic        exp_write;

   lsu_mem_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_a      (mem_a),
      .mem_we     (mem_we),
      .mem_din    (mem_din),
      .mem_spo    (mem_spo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) tb_mem[mem_a] <= mem_din;
      else if (pre_we) tb_mem[pre_a] <= pre_d;
   end
   assign mem_spo = tb_mem[mem_a];

   task automatic pre_write(input logic [15:0] a, input logic [31:0] d);
      pre_we = 1'b1;
      pre_a  = a;
      pre_d  = d;
      ref_mem[a] = d;
      @(posedge clk);
      #1;
      pre_we = 1'b0;
   endtask

   // Reference model: RV32 load/store semantics on a byte view of the word memory.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
      logic        legal;
      int          nb;
      int          sh;
      logic [31:0] v;
      logic [31:0] m;
      legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
      nb = 1 << f3[1:0];
      sh = int'(addr[1:0]);
      exp_err = !legal || ((addr[2:0] & 3'(nb - 1)) != 3'd0);
`ifdef LSU_ADDR_CHECK_EN
      if (addr >= 32'h0004_0000) exp_err = 1'b1;
`endif
      exp_word  = addr[17:2];
      exp_write = we && !exp_err;
      exp_lat   = (exp_write && nb < 4) ? 3 : 2;
      exp_rdata = 32'd0;
      exp_new   = ref_mem[exp_word];
      if (!exp_err && !we) begin
         m = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
         v = (ref_mem[exp_word] >> (8 * sh)) & m;
         if (!f3[2] && nb < 4 && v[8 * nb - 1]) v = v | ~m;
         exp_rdata = v;
      end
      if (exp_write) begin
         for (int i = 0; i < nb; i++) exp_new[8 * (sh + i) +: 8] = wd[8 * i +: 8];
         ref_mem[exp_word] = exp_new;
      end
   endtask

   // Issue one request in the next idle cycle and record what the DUT does.
   task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
      model(we, f3, addr, wd);
      @(posedge clk);
      #1;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      #1;
      obs_ready_issue = req_ready;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom_range(0, 7));
      req_addr   = $urandom;
      req_wdata  = $urandom;
      obs_lat = -1;
      obs_we_cnt = 0;
      obs_we_k = 0;
      obs_we_a = '0;
      obs_we_din = '0;
      obs_a1 = '0;
      obs_we1 = 1'b0;
      obs_rdata = '0;
      obs_err = 1'b0;
      obs_ready_resp = 1'b0;
      for (int k = 1; k <= 8 && obs_lat < 0; k++) begin
         @(negedge clk);
         if (k == 1) begin
            obs_a1  = mem_a;
            obs_we1 = mem_we;
         end
         if (mem_we) begin
            obs_we_cnt++;
            obs_we_k   = k;
            obs_we_a   = mem_a;
            obs_we_din = mem_din;
         end
         if (resp_valid) begin
            obs_lat        = k;
            obs_rdata      = resp_rdata;
            obs_err        = resp_err;
            obs_ready_resp = req_ready;
         end
      end
      $display("req we=%0d f3=%0d addr=%h wdata=%h -> lat=%0d err=%0d rdata=%h writes=%0d",
               we, f3, addr, wd, obs_lat, obs_err, obs_rdata, obs_we_cnt);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
      n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
      n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
      n_cmp++; if (mem_a !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_a got=%h exp=0000", mem_a); end
      n_cmp++; if (mem_din !== 32'h0) begin n_fail++; $display("FAIL reset_mem_din got=%h exp=0", mem_din); end
      n_cmp++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata got=%h exp=0", resp_rdata); end
      n_cmp++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
      for (int i = 0; i < 16; i++) pre_write(16'(i), $urandom);
      pre_write(16'h0000, 32'h0BAD_F00D);
      pre_write(16'h0004, 32'h8899_AABB);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_req_ready got=%b exp=1", req_ready); end
   endtask

   task automatic test_loads();
      logic [2:0]  f3_t [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
      logic [31:0] ad_t [5] = '{32'h10, 32'h13, 32'h12, 32'h10, 32'h10};
      logic [31:0] ex_t [5] = '{32'hFFFF_FFBB, 32'h0000_0088, 32'hFFFF_8899, 32'h0000_AABB, 32'h8899_AABB};
      for (int i = 0; i < 5; i++) begin
         run_req(1'b0, f3_t[i], ad_t[i], $urandom);
         n_cmp++; if (obs_rdata !== ex_t[i]) begin n_fail++; $display("FAIL load_rdata[%0d] got=%h exp=%h", i, obs_rdata, ex_t[i]); end
         n_cmp++; if (obs_lat !== 2) begin n_fail++; $display("FAIL load_latency[%0d] got=%0d exp=2", i, obs_lat); end
         n_cmp++; if (obs_err !== 1'b0 || obs_we_cnt !== 0) begin n_fail++; $display("FAIL load_err_we[%0d] got err=%b writes=%0d exp 0/0", i, obs_err, obs_we_cnt); end
         n_cmp++; if (obs_a1 !== 16'h0004) begin n_fail++; $display("FAIL load_mem_a[%0d] got=%h exp=0004", i, obs_a1); end
      end
   endtask

   task automatic test_addr_wrap();
      run_req(1'b0, 3'b010, 32'h0004_0000, 32'h0);
`ifdef LSU_ADDR_CHECK_EN
      n_cmp++; if (obs_err !== 1'b1 || obs_rdata !== 32'h0) begin n_fail++; $display("FAIL addr_fault got err=%b rdata=%h exp err=1 rdata=0", obs_err, obs_rdata); end
      n_cmp++; if (obs_a1 !== 16'h0000 || obs_we_cnt !== 0) begin n_fail++; $display("FAIL addr_fault_mem got a=%h writes=%0d exp 0/0", obs_a1, obs_we_cnt); end
`else
      n_cmp++; if (obs_err !== 1'b0 || obs_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL addr_wrap got err=%b rdata=%h exp err=0 rdata=0badf00d", obs_err, obs_rdata); end
`endif
      n_cmp++; if (obs_lat !== 2) begin n_fail++; $display("FAIL addr_wrap_latency got=%0d exp=2", obs_lat); end
   endtask

   task automatic test_stores();
      run_req(1'b1, 3'b000, 32'h11, 32'hFFFF_FF55);
      n_cmp++; if (obs_we1 !== 1'b0 || obs_a1 !== 16'h0004) begin n_fail++; $display("FAIL sb_rmw_rd got we=%b a=%h exp we=0 a=0004", obs_we1, obs_a1); end
      n_cmp++; if (obs_we_cnt !== 1 || obs_we_k !== 2) begin n_fail++; $display("FAIL sb_we_pulse got count=%0d cycle=%0d exp 1 at 2", obs_we_cnt, obs_we_k); end
      n_cmp++; if (obs_we_din !== 32'h8899_55BB || obs_we_a !== 16'h0004) begin n_fail++; $display("FAIL sb_write got a=%h din=%h exp a=0004 din=889955bb", obs_we_a, obs_we_din); end
      n_cmp++; if (obs_lat !== 3 || obs_err !== 1'b0 || obs_rdata !== 32'h0) begin n_fail++; $display("FAIL sb_resp got lat=%0d err=%b rdata=%h exp 3/0/0", obs_lat, obs_err, obs_rdata); end
      run_req(1'b0, 3'b010, 32'h10, 32'h0);
      n_cmp++; if (obs_rdata !== 32'h8899_55BB) begin n_fail++; $display("FAIL sb_readback got=%h exp=889955bb", obs_rdata); end
      run_req(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF);
      n_cmp++; if (obs_we_cnt !== 1 || obs_we_k !== 1) begin n_fail++; $display("FAIL sw_we_pulse got count=%0d cycle=%0d exp 1 at 1", obs_we_cnt, obs_we_k); end
      n_cmp++; if (obs_we_a !== 16'h0008 || obs_we_din !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_write got a=%h din=%h exp a=0008 din=deadbeef", obs_we_a, obs_we_din); end
      n_cmp++; if (obs_lat !== 2) begin n_fail++; $display("FAIL sw_latency got=%0d exp=2", obs_lat); end
      run_req(1'b1, 3'b001, 32'h22, 32'hABCD_1234);
      n_cmp++; if (obs_we_din !== 32'h1234_BEEF || obs_lat !== 3) begin n_fail++; $display("FAIL sh_write got din=%h lat=%0d exp din=1234beef lat=3", obs_we_din, obs_lat); end
      n_cmp++; if (tb_mem[8] !== 32'h1234_BEEF) begin n_fail++; $display("FAIL sh_memory got=%h exp=1234beef", tb_mem[8]); end
   endtask

   task automatic test_errors();
      logic        we_t [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [2:0]  f3_t [7] = '{3'd2, 3'd1, 3'd3, 3'd3, 3'd7, 3'd6, 3'd5};
      logic [31:0] ad_t [7] = '{32'h02, 32'h01, 32'h10, 32'h10, 32'h10, 32'h10, 32'h13};
      for (int i = 0; i < 7; i++) begin
         run_req(we_t[i], f3_t[i], ad_t[i], $urandom);
         n_cmp++; if (obs_err !== 1'b1 || obs_rdata !== 32'h0) begin n_fail++; $display("FAIL err_resp[%0d] got err=%b rdata=%h exp err=1 rdata=0", i, obs_err, obs_rdata); end
         n_cmp++; if (obs_we_cnt !== 0 || obs_a1 !== 16'h0) begin n_fail++; $display("FAIL err_no_access[%0d] got writes=%0d a=%h exp 0/0", i, obs_we_cnt, obs_a1); end
         n_cmp++; if (obs_lat !== 2) begin n_fail++; $display("FAIL err_latency[%0d] got=%0d exp=2", i, obs_lat); end
      end
   endtask

   task automatic test_reset_abort();
      int bad;
      @(posedge clk);
      #1;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b000;
      req_addr   = 32'h10;
      req_wdata  = 32'h0000_00AA;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (mem_we !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL abort_rst_cycle got we=%b resp=%b exp 0/0", mem_we, resp_valid); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      bad = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (mem_we !== 1'b0 || resp_valid !== 1'b0) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL abort_quiet got active_cycles=%0d exp=0", bad); end
      n_cmp++; if (tb_mem[4] !== 32'h8899_55BB) begin n_fail++; $display("FAIL abort_memory got=%h exp=889955bb", tb_mem[4]); end
      $display("req we=1 f3=0 addr=00000010 wdata=000000aa -> aborted by reset");
      run_req(1'b0, 3'b010, 32'h10, 32'h0);
      n_cmp++; if (obs_rdata !== 32'h8899_55BB || obs_lat !== 2) begin n_fail++; $display("FAIL abort_recover got rdata=%h lat=%0d exp 889955bb/2", obs_rdata, obs_lat); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      for (int i = 0; i < 80; i++) begin
         a = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFC_0000);
         run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
         n_cmp++; if (obs_lat !== exp_lat) begin n_fail++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", i, obs_lat, exp_lat); end
         n_cmp++; if (obs_err !== exp_err || obs_rdata !== exp_rdata) begin n_fail++; $display("FAIL b2b_resp[%0d] got err=%b rdata=%h exp err=%b rdata=%h", i, obs_err, obs_rdata, exp_err, exp_rdata); end
         n_cmp++; if (obs_we_cnt !== int'(exp_write)) begin n_fail++; $display("FAIL b2b_we_count[%0d] got=%0d exp=%0d", i, obs_we_cnt, exp_write); end
         n_cmp++; if (obs_a1 !== (exp_err ? 16'h0 : exp_word)) begin n_fail++; $display("FAIL b2b_mem_a[%0d] got=%h exp=%h", i, obs_a1, exp_err ? 16'h0 : exp_word); end
         n_cmp++; if (obs_ready_issue !== 1'b1 || obs_ready_resp !== 1'b0) begin n_fail++; $display("FAIL b2b_ready[%0d] got issue=%b resp=%b exp 1/0", i, obs_ready_issue, obs_ready_resp); end
         if (exp_write) begin
            n_cmp++; if (obs_we_a !== exp_word || obs_we_din !== exp_new) begin n_fail++; $display("FAIL b2b_write[%0d] got a=%h din=%h exp a=%h din=%h", i, obs_we_a, obs_we_din, exp_word, exp_new); end
         end
      end
      for (int w = 0; w < 16; w++) begin
         n_cmp++; if (tb_mem[w] !== ref_mem[w]) begin n_fail++; $display("FAIL final_memory[%0d] got=%h exp=%h", w, tb_mem[w], ref_mem[w]); end
      end
   endtask

   initial begin
      n_cmp      = 0;
      n_fail     = 0;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      pre_we     = 1'b0;
      pre_a      = 16'h0;
      pre_d      = 32'h0;
      test_reset();
      test_loads();
      test_addr_wrap();
      test_stores();
      test_errors();
      test_reset_abort();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
